// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state, click-count and timing constants for the button press classifier
package btn_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRESS     = 2'd1;
    localparam logic [1:0] ST_GAP       = 2'd2;
    localparam logic [1:0] ST_LONG_HELD = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        PRESS     = ST_PRESS,
        GAP       = ST_GAP,
        LONG_HELD = ST_LONG_HELD
    } state_t;

    localparam logic [2:0] CLK_0   = 3'd0;
    localparam logic [2:0] CLK_1   = 3'd1;
    localparam logic [2:0] CLK_2   = 3'd2;
    localparam logic [2:0] CLK_3   = 3'd3;
    localparam logic [2:0] CLK_4   = 3'd4;
    localparam logic [2:0] CLK_MAX = CLK_4;

    // Bit positions inside the registered event vector
    localparam int EV_SHORT  = 0;
    localparam int EV_DOUBLE = 1;
    localparam int EV_TRIPLE = 2;
    localparam int EV_FOUR   = 3;
    localparam int EV_LONG   = 4;
    localparam int EV_W      = 5;

    localparam int DEF_DEB_CYC    = 1_000_000;
    localparam int DEF_LONG_CYC   = 100_000_000;
    localparam int DEF_GAP_CYC    = 30_000_000;
    localparam int DEF_REPEAT_CYC = 20_000_000;

    function automatic logic [2:0] clicks_inc(input logic [2:0] c);
        return (c >= CLK_MAX) ? CLK_MAX : c + 3'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser plus stable-count debouncer for one raw button
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEB_CYC = DEF_DEB_CYC
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic btn_level
);

    localparam int CW = $clog2(DEB_CYC) + 1;

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // Level flips on the edge where the mismatch has lasted DEB_CYC cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYC - 1)) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign btn_level = level;

endmodule

// File: rtl/button_press_classifier.sv
// rtl/button_press_classifier.sv - debounced button gesture classifier (short/double/triple/four/long); BTN_LONG_REPEAT_EN adds set_repeat
module button_press_classifier
    import btn_pkg::*;
#(
    parameter int DEB_CYC    = DEF_DEB_CYC,
    parameter int LONG_CYC   = DEF_LONG_CYC,
    parameter int GAP_CYC    = DEF_GAP_CYC
`ifdef BTN_LONG_REPEAT_EN
    ,
    parameter int REPEAT_CYC = DEF_REPEAT_CYC
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic btn_level,
    output logic set_short,
    output logic set_double,
    output logic set_triple,
    output logic set_four,
    output logic set_long
`ifdef BTN_LONG_REPEAT_EN
    ,
    output logic set_repeat
`endif
);

    localparam int HW = $clog2(LONG_CYC) + 1;
    localparam int GW = $clog2(GAP_CYC) + 1;

    logic            level;
    state_t          state, state_n;
    logic [HW-1:0]   hold_cnt, hold_n, hold_inc;
    logic [GW-1:0]   gap_cnt, gap_n, gap_inc;
    logic [2:0]      clicks, clicks_n;
    logic [EV_W-1:0] ev, ev_n;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_debounce (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn       (btn),
        .btn_level (level)
    );

    assign hold_inc = (hold_cnt == HW'(LONG_CYC - 1)) ? hold_cnt : hold_cnt + 1'b1;
    assign gap_inc  = (gap_cnt == GW'(GAP_CYC - 1)) ? gap_cnt : gap_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            clicks   <= CLK_0;
            ev       <= '0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            gap_cnt  <= gap_n;
            clicks   <= clicks_n;
            ev       <= ev_n;
        end
    end

    always_comb begin
        state_n  = state;
        hold_n   = hold_cnt;
        gap_n    = gap_cnt;
        clicks_n = clicks;
        ev_n     = '0;
        case (state)
            IDLE: begin
                if (level) begin
                    state_n  = PRESS;
                    hold_n   = '0;
                    clicks_n = CLK_1;
                end
            end
            PRESS: begin
                if (!level) begin
                    state_n = GAP;
                    gap_n   = '0;
                end else begin
                    hold_n = hold_inc;
                    // A long press swallows any clicks already collected
                    if (hold_inc == HW'(LONG_CYC - 1)) begin
                        ev_n[EV_LONG] = 1'b1;
                        clicks_n      = CLK_0;
                        state_n       = LONG_HELD;
                    end
                end
            end
            GAP: begin
                if (level) begin
                    clicks_n = clicks_inc(clicks);
                    hold_n   = '0;
                    state_n  = PRESS;
                end else begin
                    gap_n = gap_inc;
                    if (gap_inc == GW'(GAP_CYC - 1)) begin
                        case (clicks)
                            CLK_1:   ev_n[EV_SHORT]  = 1'b1;
                            CLK_2:   ev_n[EV_DOUBLE] = 1'b1;
                            CLK_3:   ev_n[EV_TRIPLE] = 1'b1;
                            default: ev_n[EV_FOUR]   = 1'b1;
                        endcase
                        clicks_n = CLK_0;
                        state_n  = IDLE;
                    end
                end
            end
            LONG_HELD: begin
                if (!level) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef BTN_LONG_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYC) + 1;

    logic [RW-1:0] rep_cnt, rep_n;
    logic          rep_q, rep_pulse_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_cnt <= '0;
            rep_q   <= 1'b0;
        end else begin
            rep_cnt <= rep_n;
            rep_q   <= rep_pulse_n;
        end
    end

    always_comb begin
        rep_n       = '0;
        rep_pulse_n = 1'b0;
        if (state == LONG_HELD && level) begin
            if (rep_cnt == RW'(REPEAT_CYC - 1)) begin
                rep_pulse_n = 1'b1;
            end else begin
                rep_n = rep_cnt + 1'b1;
            end
        end
    end

    assign set_repeat = rep_q;
`endif

    assign btn_level  = level;
    assign set_short  = ev[EV_SHORT];
    assign set_double = ev[EV_DOUBLE];
    assign set_triple = ev[EV_TRIPLE];
    assign set_four   = ev[EV_FOUR];
    assign set_long   = ev[EV_LONG];

endmodule
